// File: rtl/gpu_avm_bridge.sv
// gpu_avm_bridge: converts GPU VRAM word requests into Avalon-MM burst
// transactions. Writes are issued one beat per GPU handshake, and reads
// return data to the GPU one cycle after each Avalon beat. A read that
// stalls for too long is abandoned. Protocol violations are flagged in
// sticky status bits.
module gpu_avm_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst,
    // GPU side
    input  logic [16:0] i_targetAddr,
    input  logic [2:0]  i_burstLength,
    input  logic        i_writeEnableMem,
    input  logic        i_readEnableMem,
    input  logic [63:0] i_dataMem,
    input  logic [7:0]  i_byteEnableMem,
    output logic        o_busyMem,
    output logic        o_dataValidMem,
    output logic [63:0] o_dataMem,
    // Avalon-MM master
    output logic [31:0] avm_address,
    output logic [2:0]  avm_burstcount,
    output logic        avm_read,
    output logic        avm_write,
    output logic [63:0] avm_writedata,
    output logic [7:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [63:0] avm_readdata,
    // status
    output logic        o_protoErr,
    output logic        o_timeout
);

    // The counter only needs to reach RD_TIMEOUT-1 before the abort fires.
    localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_GAP   = 3'd2,
        RD_ISSUE = 3'd3,
        RD_DATA  = 3'd4
    } state_t;

    state_t         state_q;
    logic [31:0]    addr_q;
    logic [2:0]     bcnt_q;
    logic [2:0]     rem_q;
    logic [63:0]    wdata_q;
    logic [7:0]     be_q;
    logic [TW-1:0]  tcnt_q;
    logic [63:0]    rdata_q;
    logic           dvalid_q;
    logic           busy_q;
    logic           rd_q;
    logic           wr_q;
    logic           perr_q;
    logic           tout_q;

    logic [2:0]     beats_d;
    logic [31:0]    addr_d;
    logic           tmo_hit;

    // A zero burst length means a single beat. The word address becomes a
    // byte address and is added to the window base, wrapping at 2^32.
    assign beats_d = (i_burstLength == 3'd0) ? 3'd1 : i_burstLength;
    assign addr_d  = BASE_ADDR + {12'd0, i_targetAddr, 3'b000};
    assign tmo_hit = (tcnt_q == TW'(RD_TIMEOUT - 1));

    // Bridge FSM. All outputs are registered and updated together with the state.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            bcnt_q   <= '0;
            rem_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            tcnt_q   <= '0;
            rdata_q  <= '0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            perr_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            dvalid_q <= 1'b0;
            // Read data with no read outstanding is dropped. This includes
            // beats from a burst that was cut short by reset.
            if (avm_readdatavalid && (state_q != RD_DATA)) begin
                perr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_writeEnableMem) begin
                        addr_q   <= addr_d;
                        bcnt_q   <= beats_d;
                        rem_q    <= beats_d;
                        wdata_q  <= i_dataMem;
                        be_q     <= i_byteEnableMem;
                        wr_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= WR_ISSUE;
                        // The write wins. The simultaneous read is lost.
                        if (i_readEnableMem) begin
                            perr_q <= 1'b1;
                        end
                    end else if (i_readEnableMem) begin
                        addr_q  <= addr_d;
                        bcnt_q  <= beats_d;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (!avm_waitrequest) begin
                        rem_q   <= rem_q - 3'd1;
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= (rem_q == 3'd1) ? IDLE : WR_GAP;
                    end
                end
                WR_GAP: begin
                    // Mid-burst, only the next write beat is legal.
                    if (i_readEnableMem) begin
                        perr_q <= 1'b1;
                    end
                    if (i_writeEnableMem) begin
                        wdata_q <= i_dataMem;
                        be_q    <= i_byteEnableMem;
                        wr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WR_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (!avm_waitrequest) begin
                        rd_q    <= 1'b0;
                        rem_q   <= bcnt_q;
                        tcnt_q  <= '0;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (avm_readdatavalid) begin
                        rdata_q  <= avm_readdata;
                        dvalid_q <= 1'b1;
                        rem_q    <= rem_q - 3'd1;
                        tcnt_q   <= '0;
                        if (rem_q == 3'd1) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        tout_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busyMem      = busy_q;
    assign o_dataValidMem = dvalid_q;
    assign o_dataMem      = rdata_q;
    assign avm_address    = addr_q;
    assign avm_burstcount = bcnt_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign o_protoErr     = perr_q;
    assign o_timeout      = tout_q;

endmodule

// File: doc/gpu_avm_bridge.md
GPU_AVM_BRIDGE -- requirements
Module: gpu_avm_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base of the GPU VRAM window on the Avalon fabric.
REQ-002 SHALL have parameter RD_TIMEOUT, default 255: max cycles waited in RD_DATA before abort.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have GPU-side inputs: i_targetAddr 17 (64-bit word address), i_burstLength 3 (beats), i_writeEnableMem 1, i_readEnableMem 1, i_dataMem 64, i_byteEnableMem 8.
REQ-006 SHALL have GPU-side outputs: o_busyMem 1 (wait request to GPU), o_dataValidMem 1, o_dataMem 64.
REQ-007 SHALL have Avalon outputs: avm_address 32 (byte address), avm_burstcount 3, avm_read 1, avm_write 1, avm_writedata 64, avm_byteenable 8.
REQ-008 SHALL have Avalon inputs: avm_waitrequest 1, avm_readdatavalid 1, avm_readdata 64.
REQ-009 SHALL have status outputs: o_protoErr 1 (sticky), o_timeout 1 (sticky).

Function
REQ-010 SHALL implement states IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_DATA.
REQ-011 SHALL accept a GPU request only when i_*EnableMem=1 and o_busyMem=0 in the same cycle.
REQ-012 SHALL drive o_busyMem=0 in IDLE and WR_GAP, 1 in WR_ISSUE, RD_ISSUE, RD_DATA.
REQ-013 SHALL compute beats = i_burstLength, with 0 mapped to 1; avm_burstcount = beats, latched at first accepted beat.
REQ-014 SHALL compute avm_address = BASE_ADDR + {i_targetAddr,3'b000}, 32-bit, wrapping modulo 2^32, latched at first beat and held for the whole burst.
REQ-015 IDLE + write accepted: latch address, beats, data, byteenable; remaining=beats; -> WR_ISSUE next cycle.
REQ-016 IDLE + read accepted: latch address, beats; -> RD_ISSUE next cycle.
REQ-017 IDLE with both enables high: write SHALL win, read dropped, o_protoErr set.
REQ-018 WR_ISSUE: avm_write=1 with latched data/byteenable held stable while avm_waitrequest=1; on avm_waitrequest=0 decrement remaining; if it was 1 -> IDLE, else -> WR_GAP.
REQ-019 WR_GAP: avm_write=0; on i_writeEnableMem latch new data/byteenable -> WR_ISSUE; i_readEnableMem here SHALL be ignored and set o_protoErr.
REQ-020 RD_ISSUE: avm_read=1 held while avm_waitrequest=1; on avm_waitrequest=0 -> RD_DATA, remaining=beats, timeout counter=0.
REQ-021 RD_DATA: each avm_readdatavalid=1 SHALL register avm_readdata to o_dataMem and pulse o_dataValidMem=1 exactly one cycle later (latency 1); decrement remaining; last beat -> IDLE.
REQ-022 RD_DATA: timeout counter increments on cycles without avm_readdatavalid, clears on each beat; reaching RD_TIMEOUT SHALL set o_timeout and force IDLE.
REQ-023 avm_readdatavalid outside RD_DATA SHALL be ignored (no o_dataValidMem) and set o_protoErr.
REQ-024 avm_read and avm_write SHALL never be high in the same cycle.
REQ-025 o_dataMem SHALL hold its last value when o_dataValidMem=0.
REQ-026 Back-to-back bursts: a new request accepted in IDLE in the cycle after the last beat completes SHALL be issued with no further bubble.

Reset
REQ-027 On i_rst=1 (asynchronous, any state, including mid-burst) SHALL go to IDLE; avm_read=0, avm_write=0, o_dataValidMem=0, o_busyMem=0, o_protoErr=0, o_timeout=0, avm_address/burstcount/writedata/byteenable/o_dataMem=0.
REQ-028 Read beats arriving after reset deassertion from a burst aborted by reset SHALL be treated per REQ-023.

Verification
REQ-029 Single write: addr=17'h00010, burst=1, data=64'hDEAD_BEEF_0123_4567, be=8'hFF, waitrequest low -> one avm_write cycle, avm_address=32'h80, burstcount=1, back to IDLE.
REQ-030 4-beat write with waitrequest high 3 cycles on beat 2 -> avm_writedata beat 2 stable across stall, exactly 4 avm_write accepts, address 32'h80 held throughout.
REQ-031 4-beat read addr=17'h1FFFF, BASE_ADDR=32'h3000_0000 -> avm_address=32'h300F_FFF8, 4 readdatavalid beats each echoed 1 cycle later on o_dataValidMem, busy low after last.
REQ-032 Read with only 2 of 4 beats returned, RD_TIMEOUT=8 -> o_timeout=1 after 8 idle cycles, IDLE reached, o_busyMem=0.
REQ-033 Stray avm_readdatavalid in IDLE, and simultaneous read+write enables -> o_protoErr=1, no o_dataValidMem, write issued.
REQ-034 i_rst pulsed during RD_DATA after beat 1 -> all outputs at reset values immediately; late beats ignored, o_protoErr=1.
